// File: rtl/sc_resolve_unit.sv
// Store-conditional resolver: samples the forwarded link bit, issues the SC store, and reports the result.
// Optional feature macro: LLSC_ADDR_CHECK_EN also requires the SC word address to match the last LL address.
module sc_resolve_unit #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_LSB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              sc_valid_i,
  input  logic [ADDR_W-1:0] sc_addr_i,
  input  logic [DATA_W-1:0] sc_data_i,
  input  logic              LLbit_i,
  input  logic              wb_LLbit_we_i,
  input  logic              wb_LLbit_i,
  input  logic              ll_commit_i,
  input  logic [ADDR_W-1:0] ll_addr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  output logic              stallreq_o,
  output logic              sc_done_o,
  output logic [DATA_W-1:0] sc_result_o,
  output logic              LLbit_we_o,
  output logic              LLbit_o
);

  typedef enum logic [1:0] {IDLE, STORE, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } st_req_t;

  state_t            state;
  st_req_t           st_req;
  logic [DATA_W-1:0] result;
  logic              link;
  logic              pass;

  // A WB-stage LLbit write in the same cycle overrides the committed value.
  assign link = wb_LLbit_we_i ? wb_LLbit_i : LLbit_i;

`ifdef LLSC_ADDR_CHECK_EN
  logic [ADDR_W-1:0] link_addr;
  logic [ADDR_W-1:0] link_addr_eff;

  // Forward a retiring LL address so a same-cycle SC compares against it.
  assign link_addr_eff = ll_commit_i ? ll_addr_i : link_addr;
  assign pass = link & (sc_addr_i[ADDR_W-1:ADDR_LSB] == link_addr_eff[ADDR_W-1:ADDR_LSB]);

  always_ff @(posedge clk) begin
    if (rst)              link_addr <= '0;
    else if (ll_commit_i) link_addr <= ll_addr_i;
  end
`else
  logic unused_ll;
  assign unused_ll = ^{ll_commit_i, ll_addr_i[ADDR_W-1:ADDR_LSB], ll_addr_i[ADDR_LSB-1:0]};
  assign pass      = link;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      st_req <= '0;
      result <= '0;
    end else if (flush) begin
      // A flushed SC leaves no result and no link write; the link register clears itself.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (sc_valid_i) begin
            if (pass) begin
              state       <= STORE;
              st_req.addr <= sc_addr_i;
              st_req.data <= sc_data_i;
            end else begin
              state  <= DONE;
              result <= '0;
            end
          end
        end
        STORE: begin
          if (mem_ack_i) begin
            state  <= DONE;
            result <= DATA_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register; only the IDLE stall follows sc_valid_i.
  assign mem_req_o   = (state == STORE);
  assign mem_addr_o  = st_req.addr;
  assign mem_data_o  = st_req.data;
  assign stallreq_o  = (state == STORE) | ((state == IDLE) & sc_valid_i);
  assign sc_done_o   = (state == DONE);
  assign sc_result_o = result;
  assign LLbit_we_o  = (state == DONE);
  assign LLbit_o     = 1'b0;

endmodule

// File: tb/tb_sc_resolve_unit.sv
// Randomized bench for sc_resolve_unit against a transaction-level model of SC outcomes and latency.
module tb_sc_resolve_unit;

  logic        clk = 1'b0;
  logic        rst, flush, sc_valid_i, LLbit_i, wb_LLbit_we_i, wb_LLbit_i, ll_commit_i, mem_ack_i;
  logic [31:0] sc_addr_i, sc_data_i, ll_addr_i;
  logic        mem_req_o, stallreq_o, sc_done_o, LLbit_we_o, LLbit_o;
  logic [31:0] mem_addr_o, mem_data_o, sc_result_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ll_addr_m = '0;

  always #5 clk = ~clk;

  sc_resolve_unit #(.ADDR_W(32), .DATA_W(32), .ADDR_LSB(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .sc_valid_i(sc_valid_i), .sc_addr_i(sc_addr_i),
    .sc_data_i(sc_data_i), .LLbit_i(LLbit_i), .wb_LLbit_we_i(wb_LLbit_we_i), .wb_LLbit_i(wb_LLbit_i),
    .ll_commit_i(ll_commit_i), .ll_addr_i(ll_addr_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .stallreq_o(stallreq_o), .sc_done_o(sc_done_o),
    .sc_result_o(sc_result_o), .LLbit_we_o(LLbit_we_o), .LLbit_o(LLbit_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; sc_valid_i = 0; LLbit_i = 0; wb_LLbit_we_i = 0; wb_LLbit_i = 0;
    ll_commit_i = 0; mem_ack_i = 0; sc_addr_i = '0; sc_data_i = '0; ll_addr_i = '0;
  endtask

  // One SC from the pipeline's view. Counts of request, stall and done cycles are compared
  // with what the link/latency rules predict. fl_at: cycle of flush (99 none, -1 pick at random).
  task automatic sc_txn(input string tag, input bit llb, input bit fwe, input bit fval,
                        input logic [31:0] addr, input logic [31:0] data, input int n_ack,
                        input int fl_at_in, input bit ll_c, input logic [31:0] ll_a);
    int req = 0, stl = 0, dn = 0, we = 0, bad = 0, fl_at;
    int e_req, e_stl, e_dn;
    logic [31:0] res = '0, e_res;
    bit drop = 0, link, match, ok;
    logic [31:0] ea;
    link = fwe ? fval : llb;
    ea = ll_c ? ll_a : ll_addr_m;
`ifdef LLSC_ADDR_CHECK_EN
    match = (addr[31:2] == ea[31:2]);
`else
    match = 1'b1;
`endif
    if (ll_c) ll_addr_m = ll_a;
    ok = link & match;
    fl_at = fl_at_in;
    if (fl_at == -1) fl_at = ok ? int'($urandom_range(0, n_ack)) : 0;
    if (fl_at == 0)               begin e_req = 0;     e_stl = 1;         e_dn = 0; e_res = 0; end
    else if (ok && fl_at <= n_ack) begin e_req = fl_at; e_stl = 1 + fl_at; e_dn = 0; e_res = 0; end
    else if (ok)                  begin e_req = n_ack; e_stl = 1 + n_ack; e_dn = 1; e_res = 1; end
    else                          begin e_req = 0;     e_stl = 1;         e_dn = 1; e_res = 0; end
    for (int c = 0; c < n_ack + 6; c++) begin
      sc_valid_i = !drop; LLbit_i = llb; wb_LLbit_we_i = (c == 0) && fwe; wb_LLbit_i = fval;
      ll_commit_i = (c == 0) && ll_c; ll_addr_i = ll_a; mem_ack_i = (c == n_ack);
      flush = (c == fl_at); sc_addr_i = addr; sc_data_i = data;
      @(negedge clk);
      if (mem_req_o) begin req++; if (mem_addr_o !== addr || mem_data_o !== data) bad++; end
      if (stallreq_o) stl++;
      if (sc_done_o) begin dn++; res = sc_result_o; end
      if (LLbit_we_o) begin we++; if (LLbit_o !== 1'b0) bad++; end
      if (sc_done_o || flush) drop = 1;
      @(posedge clk); #1;
    end
    idle_inputs();
    chk({tag, ".req"}, req, e_req);
    chk({tag, ".stall"}, stl, e_stl);
    chk({tag, ".done"}, dn, e_dn);
    chk({tag, ".llwe"}, we, e_dn);
    chk({tag, ".result"}, res, e_res);
    chk({tag, ".bus"}, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int rq, dn;
    logic [31:0] rs[$];
    bit ll_reg, clr;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset.ctl", {mem_req_o, stallreq_o, sc_done_o, LLbit_we_o}, 0);
    chk("reset.result", sc_result_o, 0);
    chk("reset.addr", mem_addr_o, 0);
    chk("reset.data", mem_data_o, 0);
    @(posedge clk); #1;
    rst = 0;
    ll_addr_m = '0;

    sc_txn("t1_success", 1, 0, 0, 32'h100, 32'hA5, 3, 99, 1, 32'h100);
    sc_txn("t2_fail", 0, 0, 0, 32'h100, 32'h5A, 2, 99, 1, 32'h100);
    sc_txn("t3_forward", 0, 1, 1, 32'h140, 32'h77, 2, 99, 1, 32'h140);
    sc_txn("t3_fwd_clear", 1, 1, 0, 32'h140, 32'h77, 2, 99, 1, 32'h140);
    sc_txn("t4_flush", 1, 0, 0, 32'h180, 32'h33, 4, 2, 1, 32'h180);
    sc_txn("flush_ack", 1, 0, 0, 32'h180, 32'h34, 2, 2, 1, 32'h180);
    sc_txn("flush_idle", 1, 0, 0, 32'h180, 32'h35, 2, 0, 1, 32'h180);
`ifdef LLSC_ADDR_CHECK_EN
    sc_txn("t5_mismatch", 1, 0, 0, 32'h204, 32'h11, 2, 99, 1, 32'h200);
    sc_txn("t5_lowbits", 1, 0, 0, 32'h202, 32'h22, 2, 99, 1, 32'h200);
`endif

    // Back-to-back SCs with the link register modelled by the bench.
    ll_reg = 1; rq = 0; dn = 0;
    for (int c = 0; c < 10; c++) begin
      sc_valid_i = (c < 6); LLbit_i = ll_reg; mem_ack_i = (c == 2);
      sc_addr_i = ll_addr_m; sc_data_i = 32'hBEEF;
      @(negedge clk);
      if (mem_req_o) rq++;
      if (sc_done_o) begin dn++; rs.push_back(sc_result_o); end
      clr = LLbit_we_o;
      @(posedge clk); #1;
      if (clr) ll_reg = 0;
    end
    idle_inputs();
    chk("t6.done", dn, 2);
    chk("t6.req", rq, 2);
    chk("t6.first", (rs.size() > 0) ? rs[0] : 32'hX, 1);
    chk("t6.second", (rs.size() > 1) ? rs[1] : 32'hX, 0);

    // Reset during STORE; a later ack must not complete anything.
    rq = 0; dn = 0;
    for (int c = 0; c < 7; c++) begin
      sc_valid_i = (c < 3); LLbit_i = 1; sc_addr_i = ll_addr_m; sc_data_i = 32'hCAFE;
      rst = (c == 2); mem_ack_i = (c == 4);
      @(negedge clk);
      if (c >= 3 && mem_req_o) rq++;
      if (sc_done_o) dn++;
      @(posedge clk); #1;
    end
    rst = 0;
    idle_inputs();
    ll_addr_m = '0;
    chk("rst_store.req", rq, 0);
    chk("rst_store.done", dn, 0);
    chk("rst_store.addr", mem_addr_o, 0);

    for (int i = 0; i < 40; i++) begin
      bit llb, fwe, fval, llc;
      logic [31:0] lla, addr;
      llb = 1'($urandom); fwe = ($urandom % 3) == 0; fval = 1'($urandom);
      llc = ($urandom % 3) == 0;
      lla = 32'h400 + 32'(4 * $urandom_range(0, 3));
      addr = ($urandom % 4 == 0) ? $urandom : ((llc ? lla : ll_addr_m) + 32'($urandom_range(0, 5)));
      sc_txn($sformatf("rnd%0d", i), llb, fwe, fval, addr, $urandom,
             int'($urandom_range(1, 5)), ($urandom % 4 == 0) ? -1 : 99, llc, lla);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
